// File: rtl/bh1750_pkg.sv
// Shared types for the BH1750 measurement sequencer: opcodes, device address,
// sequencer state encoding.
package bh1750_pkg;

  typedef enum logic [7:0] {
    OP_PWR_ON    = 8'h01,
    OP_CONT_HRES = 8'h10,  // continuous H-resolution mode, reserved for later use
    OP_ONE_HRES  = 8'h20
  } bh1750_op_e;

  localparam logic [6:0] BH1750_ADDR = 7'h23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWR_WAIT,
    S_MODE_WAIT,
    S_CONV,
    S_READ_WAIT,
    S_CALC,
    S_PERIOD,
    S_ERR
  } seq_state_e;

  function automatic logic is_xfer_state(seq_state_e s);
    return (s == S_PWR_WAIT) || (s == S_MODE_WAIT) || (s == S_READ_WAIT);
  endfunction

endpackage

// File: rtl/bh1750_meas_seq_if.sv
// Byte-level I2C transaction handshake between the sequencer (master side)
// and the I2C bus engine (slave side).
interface bh1750_meas_seq_if;

  logic        i2c_start_flag;
  logic        i2c_wr_flag;
  logic        i2c_rd_flag;
  logic [7:0]  i2c_data_wr;
  logic [6:0]  i2c_dev_addr;
  logic        i2c_done;
  logic        i2c_nack;
  logic [15:0] i2c_data_rd;

  modport master (
    output i2c_start_flag, i2c_wr_flag, i2c_rd_flag, i2c_data_wr, i2c_dev_addr,
    input  i2c_done, i2c_nack, i2c_data_rd
  );

  modport slave (
    input  i2c_start_flag, i2c_wr_flag, i2c_rd_flag, i2c_data_wr, i2c_dev_addr,
    output i2c_done, i2c_nack, i2c_data_rd
  );

endinterface

// File: rtl/bh1750_lux_conv.sv
// Raw BH1750 count to lux: floor(raw * 5 / 6), i.e. raw / 1.2.
module bh1750_lux_conv (
  input  logic [15:0] raw,
  output logic [15:0] lux
);

  // 65535 * 5 = 327675 fits in 19 bits; the quotient always fits in 16.
  logic [18:0] raw_x5;

  assign raw_x5 = {3'b000, raw} + {1'b0, raw, 2'b00};
  assign lux    = 16'(raw_x5 / 19'd6);

endmodule

// File: rtl/bh1750_meas_seq.sv
// BH1750 measurement sequencer: power-on, one-shot H-res mode, conversion
// wait, 2-byte read, lux conversion, periodic repeat with error back-off.
module bh1750_meas_seq
  import bh1750_pkg::*;
#(
  parameter logic [7:0]  PWR_ON_CMD  = OP_PWR_ON,
  parameter logic [7:0]  MODE_CMD    = OP_ONE_HRES,
  parameter int unsigned MEAS_CYC    = 9_000_000,
  parameter int unsigned PERIOD_CYC  = 25_000_000,
  parameter int unsigned RETRY_CYC   = 5_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  bh1750_meas_seq_if.master i2c,
  output logic [15:0]       lux_data,
  output logic              lux_valid,
  output logic [15:0]       raw_data,
  output logic              busy,
  output logic              err,
  output logic [7:0]        err_cnt
);

  seq_state_e  state_q, state_d;
  logic        pwr_done_q, pwr_done_d;
  logic        start_q, start_d;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] per_q, per_d;
  logic [15:0] raw_q, raw_d;
  logic [15:0] lux_q, lux_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        fail;
  logic [15:0] lux_calc;

  bh1750_lux_conv u_lux_conv (
    .raw (raw_q),
    .lux (lux_calc)
  );

  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // and only takes effect on a rising clk edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      pwr_done_q <= 1'b0;
      start_q    <= 1'b0;
      tmr_q      <= '0;
      per_q      <= '0;
      raw_q      <= '0;
      lux_q      <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      pwr_done_q <= pwr_done_d;
      start_q    <= start_d;
      tmr_q      <= tmr_d;
      per_q      <= per_d;
      raw_q      <= raw_d;
      lux_q      <= lux_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d    = state_q;
    pwr_done_d = pwr_done_q;
    raw_d      = raw_q;
    lux_d      = lux_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    fail       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (en) state_d = pwr_done_q ? S_MODE_WAIT : S_PWR_WAIT;
      end
      S_PWR_WAIT, S_MODE_WAIT, S_READ_WAIT: begin
        // A done arriving on the timeout cycle takes priority over the timeout.
        if (i2c.i2c_done) begin
          if (i2c.i2c_nack) begin
            fail = 1'b1;
          end else if (state_q == S_PWR_WAIT) begin
            pwr_done_d = 1'b1;
            state_d    = en ? S_MODE_WAIT : S_IDLE;
          end else if (state_q == S_MODE_WAIT) begin
            state_d = en ? S_CONV : S_IDLE;
          end else begin
            raw_d   = i2c.i2c_data_rd;
            state_d = S_CALC;
          end
        end else if (tmr_q + 32'd1 >= TIMEOUT_CYC) begin
          fail = 1'b1;
        end
      end
      S_CONV: begin
        if (!en)                             state_d = S_IDLE;
        else if (tmr_q + 32'd1 >= MEAS_CYC)  state_d = S_READ_WAIT;
      end
      S_CALC: begin
        lux_d   = lux_calc;
        err_d   = 1'b0;
        state_d = en ? S_PERIOD : S_IDLE;
      end
      S_PERIOD: begin
        if (!en)                               state_d = S_IDLE;
        else if (per_q + 32'd1 >= PERIOD_CYC)  state_d = S_MODE_WAIT;
      end
      S_ERR: begin
        if (!en || (tmr_q + 32'd1 >= RETRY_CYC)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Any failed transaction forces a fresh power-on after the back-off.
    if (fail) begin
      state_d    = S_ERR;
      err_d      = 1'b1;
      pwr_done_d = 1'b0;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    // Per-state timer: timeout in transfers, conversion wait, retry back-off.
    tmr_d = (state_d != state_q || state_q == S_IDLE) ? '0 : tmr_q + 32'd1;

    // Period timer restarts with every mode command and saturates at the limit.
    per_d = per_q;
    if (state_q == S_IDLE || (state_d == S_MODE_WAIT && state_q != S_MODE_WAIT)) begin
      per_d = '0;
    end else if (per_q < PERIOD_CYC) begin
      per_d = per_q + 32'd1;
    end

    start_d = is_xfer_state(state_d) && (state_d != state_q);
  end

  always_comb begin
    i2c.i2c_start_flag = start_q;
    i2c.i2c_wr_flag    = (state_q == S_PWR_WAIT) || (state_q == S_MODE_WAIT);
    i2c.i2c_rd_flag    = (state_q == S_READ_WAIT);
    i2c.i2c_dev_addr   = BH1750_ADDR;
    if (state_q == S_PWR_WAIT)       i2c.i2c_data_wr = PWR_ON_CMD;
    else if (state_q == S_MODE_WAIT) i2c.i2c_data_wr = MODE_CMD;
    else                             i2c.i2c_data_wr = 8'h00;

    // The new value is presented in the same cycle as the valid pulse.
    lux_valid = (state_q == S_CALC);
    lux_data  = lux_valid ? lux_calc : lux_q;
    raw_data  = raw_q;
    busy      = (state_q != S_IDLE);
    err       = err_q;
    err_cnt   = err_cnt_q;
  end

endmodule

// File: tb/tb_bh1750_meas_seq.sv
// Directed bench for bh1750_meas_seq with a fixed-latency I2C transaction model.
module tb_bh1750_meas_seq;

  localparam int MEAS   = 100;
  localparam int PERIOD = 400;
  localparam int RETRY  = 50;
  localparam int TMO    = 60;
  localparam int LAT    = 20;

  localparam int Q_START = 0;
  localparam int Q_LUX   = 1;
  localparam int Q_ERR   = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [15:0] lux_data, raw_data;
  logic        lux_valid, busy, err;
  logic [7:0]  err_cnt;

  bh1750_meas_seq_if i2c_bus ();

  bh1750_meas_seq #(
    .MEAS_CYC    (MEAS),
    .PERIOD_CYC  (PERIOD),
    .RETRY_CYC   (RETRY),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .i2c       (i2c_bus),
    .lux_data  (lux_data),
    .lux_valid (lux_valid),
    .raw_data  (raw_data),
    .busy      (busy),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int          st_cyc[$];
  bit          st_wr[$];
  bit          st_rd[$];
  logic [7:0]  st_byte[$];
  int          lux_cyc[$];
  logic [15:0] lux_val[$];
  int          err_cyc[$];
  logic [15:0] rd_vals[$];
  bit          nack_next_mode = 1'b0;
  bit          hang_next_read = 1'b0;

  // Transaction model and event log, both sampled on the falling edge.
  initial begin
    int          pend_at;
    bit          pend_valid, pend_nack, err_prev;
    logic [15:0] pend_data;
    pend_valid = 1'b0;
    pend_nack  = 1'b0;
    pend_at    = 0;
    pend_data  = '0;
    err_prev   = 1'b0;
    i2c_bus.i2c_done    = 1'b0;
    i2c_bus.i2c_nack    = 1'b0;
    i2c_bus.i2c_data_rd = '0;
    forever begin
      @(negedge clk);
      i2c_bus.i2c_done    = 1'b0;
      i2c_bus.i2c_nack    = 1'b0;
      i2c_bus.i2c_data_rd = '0;
      if (lux_valid) begin
        lux_cyc.push_back(cyc);
        lux_val.push_back(lux_data);
      end
      if (err && !err_prev) err_cyc.push_back(cyc);
      err_prev = err;
      if (i2c_bus.i2c_start_flag) begin
        st_cyc.push_back(cyc);
        st_wr.push_back(i2c_bus.i2c_wr_flag);
        st_rd.push_back(i2c_bus.i2c_rd_flag);
        st_byte.push_back(i2c_bus.i2c_data_wr);
        pend_valid = 1'b1;
        pend_at    = cyc + LAT;
        pend_nack  = 1'b0;
        pend_data  = '0;
        if (i2c_bus.i2c_wr_flag && i2c_bus.i2c_data_wr == 8'h20 && nack_next_mode) begin
          pend_nack      = 1'b1;
          nack_next_mode = 1'b0;
        end
        if (i2c_bus.i2c_rd_flag) begin
          if (rd_vals.size() > 0) pend_data = rd_vals.pop_front();
          else                    pend_data = 16'h0078;
          if (hang_next_read) begin
            pend_at        = cyc + TMO + 10;
            hang_next_read = 1'b0;
          end
        end
      end else if (pend_valid && cyc == pend_at) begin
        i2c_bus.i2c_done    = 1'b1;
        i2c_bus.i2c_nack    = pend_nack;
        i2c_bus.i2c_data_rd = pend_data;
        pend_valid          = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rstn = 1'b0;
    en   = 1'b0;
    repeat (3) @(negedge clk);
    st_cyc.delete();  st_wr.delete();  st_rd.delete();  st_byte.delete();
    lux_cyc.delete(); lux_val.delete(); err_cyc.delete(); rd_vals.delete();
    nack_next_mode = 1'b0;
    hang_next_read = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic wait_count(input int which, input int n, input int budget, output bit ok);
    int sz;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      sz = (which == Q_START) ? st_cyc.size() : (which == Q_LUX) ? lux_cyc.size() : err_cyc.size();
      if (sz >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en   = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({i2c_bus.i2c_start_flag, i2c_bus.i2c_wr_flag, i2c_bus.i2c_rd_flag} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {i2c_bus.i2c_start_flag, i2c_bus.i2c_wr_flag, i2c_bus.i2c_rd_flag}); end
    n_checks++; if (i2c_bus.i2c_data_wr !== 8'h00) begin n_fail++; $display("FAIL reset_data_wr: got %h expected 00", i2c_bus.i2c_data_wr); end
    n_checks++; if ({lux_data, raw_data} !== 32'h0) begin n_fail++; $display("FAIL reset_data: got lux %h raw %h expected 0", lux_data, raw_data); end
    n_checks++; if ({lux_valid, busy, err} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b expected 000", {lux_valid, busy, err}); end
    n_checks++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    n_checks++; if (i2c_bus.i2c_dev_addr !== 7'h23) begin n_fail++; $display("FAIL dev_addr: got %h expected 23", i2c_bus.i2c_dev_addr); end
    en = 1'b0;
  endtask

  task automatic test_nominal();
    bit ok;
    do_reset();
    rd_vals.push_back(16'h0078);
    en = 1'b1;
    wait_count(Q_LUX, 1, 1500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL nom_wait: got no lux_valid expected one within 1500 cycles"); end
    n_checks++; if ({st_wr[0], st_rd[0], st_byte[0]} !== {2'b10, 8'h01}) begin n_fail++; $display("FAIL nom_pwr_cmd: got wr%b rd%b %h expected wr1 rd0 01", st_wr[0], st_rd[0], st_byte[0]); end
    n_checks++; if ({st_wr[1], st_rd[1], st_byte[1]} !== {2'b10, 8'h20}) begin n_fail++; $display("FAIL nom_mode_cmd: got wr%b rd%b %h expected wr1 rd0 20", st_wr[1], st_rd[1], st_byte[1]); end
    n_checks++; if (st_cyc[1] - st_cyc[0] != LAT + 1) begin n_fail++; $display("FAIL nom_pwr_to_mode: got %0d expected %0d", st_cyc[1] - st_cyc[0], LAT + 1); end
    n_checks++; if ({st_wr[2], st_rd[2]} !== 2'b01) begin n_fail++; $display("FAIL nom_read_flags: got wr%b rd%b expected wr0 rd1", st_wr[2], st_rd[2]); end
    n_checks++; if (st_cyc[2] - (st_cyc[1] + LAT) < MEAS) begin n_fail++; $display("FAIL nom_conv_wait: got %0d expected >= %0d", st_cyc[2] - (st_cyc[1] + LAT), MEAS); end
    n_checks++; if (lux_cyc[0] - st_cyc[1] != 2 * LAT + MEAS + 2) begin n_fail++; $display("FAIL nom_latency: got %0d expected %0d", lux_cyc[0] - st_cyc[1], 2 * LAT + MEAS + 2); end
    n_checks++; if (lux_val[0] !== 16'd100) begin n_fail++; $display("FAIL nom_lux: got %0d expected 100", lux_val[0]); end
    @(negedge clk);
    n_checks++; if (raw_data !== 16'h0078) begin n_fail++; $display("FAIL nom_raw: got %h expected 0078", raw_data); end
    n_checks++; if ({err, busy} !== 2'b01) begin n_fail++; $display("FAIL nom_err_busy: got err%b busy%b expected err0 busy1", err, busy); end
    n_checks++; if (lux_data !== 16'd100) begin n_fail++; $display("FAIL nom_lux_hold: got %0d expected 100", lux_data); end
    en = 1'b0;
  endtask

  task automatic test_periodic();
    bit ok;
    int n_pwr;
    do_reset();
    rd_vals.push_back(16'h0000);
    rd_vals.push_back(16'hFFFF);
    en = 1'b1;
    wait_count(Q_LUX, 2, 2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL per_wait: got %0d lux events expected 2", lux_cyc.size()); end
    n_checks++; if (st_cyc[3] - st_cyc[1] != PERIOD) begin n_fail++; $display("FAIL per_period: got %0d expected %0d", st_cyc[3] - st_cyc[1], PERIOD); end
    n_checks++; if (st_byte[3] !== 8'h20) begin n_fail++; $display("FAIL per_second_mode: got %h expected 20", st_byte[3]); end
    n_pwr = 0;
    foreach (st_byte[i]) if (st_wr[i] && st_byte[i] == 8'h01) n_pwr++;
    n_checks++; if (n_pwr != 1) begin n_fail++; $display("FAIL per_pwr_once: got %0d expected 1", n_pwr); end
    n_checks++; if (lux_val[0] !== 16'd0) begin n_fail++; $display("FAIL per_lux_min: got %0d expected 0", lux_val[0]); end
    n_checks++; if (lux_val[1] !== 16'd54612) begin n_fail++; $display("FAIL per_lux_max: got %0d expected 54612", lux_val[1]); end
    n_checks++; if (lux_cyc[1] - st_cyc[3] != 2 * LAT + MEAS + 2) begin n_fail++; $display("FAIL per_latency: got %0d expected %0d", lux_cyc[1] - st_cyc[3], 2 * LAT + MEAS + 2); end
    repeat (5) @(negedge clk);
    n_checks++; if ({lux_data, raw_data} !== {16'd54612, 16'hFFFF}) begin n_fail++; $display("FAIL per_hold: got lux %0d raw %h expected 54612 ffff", lux_data, raw_data); end
    en = 1'b0;
  endtask

  task automatic test_nack_mode();
    bit ok;
    do_reset();
    nack_next_mode = 1'b1;
    rd_vals.push_back(16'h0078);
    en = 1'b1;
    wait_count(Q_ERR, 1, 500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL nack_wait: got no err expected err within 500 cycles"); end
    n_checks++; if (err_cyc[0] - st_cyc[1] != LAT + 1) begin n_fail++; $display("FAIL nack_err_time: got %0d expected %0d", err_cyc[0] - st_cyc[1], LAT + 1); end
    n_checks++; if ({err, err_cnt} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL nack_err_set: got err%b cnt %0d expected err1 cnt 1", err, err_cnt); end
    wait_count(Q_LUX, 1, 1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL nack_recover_wait: got no lux_valid expected one within 1000 cycles"); end
    n_checks++; if ({st_wr[2], st_byte[2]} !== {1'b1, 8'h01}) begin n_fail++; $display("FAIL nack_pwr_resent: got wr%b %h expected wr1 01", st_wr[2], st_byte[2]); end
    n_checks++; if (st_cyc[2] - err_cyc[0] != RETRY + 1) begin n_fail++; $display("FAIL nack_backoff: got %0d expected %0d", st_cyc[2] - err_cyc[0], RETRY + 1); end
    n_checks++; if (st_byte[3] !== 8'h20) begin n_fail++; $display("FAIL nack_mode_resent: got %h expected 20", st_byte[3]); end
    n_checks++; if (lux_val[0] !== 16'd100) begin n_fail++; $display("FAIL nack_lux: got %0d expected 100", lux_val[0]); end
    @(negedge clk);
    n_checks++; if ({err, err_cnt} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL nack_err_clear: got err%b cnt %0d expected err0 cnt 1", err, err_cnt); end
    en = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    hang_next_read = 1'b1;
    rd_vals.push_back(16'h1234);
    rd_vals.push_back(16'h0078);
    en = 1'b1;
    wait_count(Q_ERR, 1, 600, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_wait: got no err expected err within 600 cycles"); end
    n_checks++; if (st_rd[2] !== 1'b1) begin n_fail++; $display("FAIL tmo_read_issued: got rd%b expected rd1", st_rd[2]); end
    n_checks++; if (err_cyc[0] - st_cyc[2] != TMO) begin n_fail++; $display("FAIL tmo_time: got %0d expected %0d", err_cyc[0] - st_cyc[2], TMO); end
    wait_count(Q_LUX, 1, 1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_recover_wait: got no lux_valid expected one within 1000 cycles"); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL tmo_late_done: got err_cnt %0d expected 1", err_cnt); end
    n_checks++; if (st_cyc[3] - err_cyc[0] != RETRY + 1) begin n_fail++; $display("FAIL tmo_backoff: got %0d expected %0d", st_cyc[3] - err_cyc[0], RETRY + 1); end
    n_checks++; if (st_byte[3] !== 8'h01) begin n_fail++; $display("FAIL tmo_pwr_resent: got %h expected 01", st_byte[3]); end
    n_checks++; if (lux_val[0] !== 16'd100) begin n_fail++; $display("FAIL tmo_lux: got %0d expected 100", lux_val[0]); end
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %b expected 0", err); end
    en = 1'b0;
  endtask

  task automatic test_en_drop_conv();
    bit ok;
    do_reset();
    en = 1'b1;
    wait_count(Q_START, 2, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL conv_drop_wait: got %0d starts expected 2", st_cyc.size()); end
    repeat (50) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL conv_drop_busy_before: got %b expected 1", busy); end
    en = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL conv_drop_idle: got busy %b expected 0", busy); end
    repeat (200) @(negedge clk);
    n_checks++; if (st_cyc.size() != 2 || lux_cyc.size() != 0) begin n_fail++; $display("FAIL conv_drop_no_read: got %0d starts %0d lux expected 2 starts 0 lux", st_cyc.size(), lux_cyc.size()); end
  endtask

  task automatic test_en_drop_read();
    bit ok;
    do_reset();
    rd_vals.push_back(16'h04B0);
    en = 1'b1;
    wait_count(Q_START, 3, 400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL read_drop_wait: got %0d starts expected 3", st_cyc.size()); end
    en = 1'b0;
    wait_count(Q_LUX, 1, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL read_drop_lux_wait: got no lux_valid expected one within 100 cycles"); end
    n_checks++; if (lux_val[0] !== 16'd1000) begin n_fail++; $display("FAIL read_drop_lux: got %0d expected 1000", lux_val[0]); end
    n_checks++; if (lux_cyc[0] - st_cyc[2] != LAT + 1) begin n_fail++; $display("FAIL read_drop_time: got %0d expected %0d", lux_cyc[0] - st_cyc[2], LAT + 1); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_drop_idle: got busy %b expected 0", busy); end
    repeat (100) @(negedge clk);
    n_checks++; if (st_cyc.size() != 3) begin n_fail++; $display("FAIL read_drop_quiet: got %0d starts expected 3", st_cyc.size()); end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    do_reset();
    rd_vals.push_back(16'h0078);
    rd_vals.push_back(16'h0078);
    en = 1'b1;
    wait_count(Q_START, 5, 1500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_mid_wait: got %0d starts expected 5", st_cyc.size()); end
    repeat (5) @(negedge clk);
    n_checks++; if ({i2c_bus.i2c_rd_flag, raw_data} !== {1'b1, 16'h0078}) begin n_fail++; $display("FAIL rst_mid_before: got rd%b raw %h expected rd1 0078", i2c_bus.i2c_rd_flag, raw_data); end
    rstn = 1'b0;
    @(negedge clk);
    n_checks++; if ({i2c_bus.i2c_start_flag, i2c_bus.i2c_wr_flag, i2c_bus.i2c_rd_flag, i2c_bus.i2c_data_wr} !== 11'h0) begin n_fail++; $display("FAIL rst_mid_i2c: got %h expected 0", {i2c_bus.i2c_start_flag, i2c_bus.i2c_wr_flag, i2c_bus.i2c_rd_flag, i2c_bus.i2c_data_wr}); end
    n_checks++; if ({lux_data, raw_data, lux_valid, busy, err, err_cnt} !== 43'h0) begin n_fail++; $display("FAIL rst_mid_outputs: got lux %h raw %h valid %b busy %b err %b cnt %0d expected all 0", lux_data, raw_data, lux_valid, busy, err, err_cnt); end
    rstn = 1'b1;
    wait_count(Q_START, 6, 50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_mid_restart_wait: got %0d starts expected 6", st_cyc.size()); end
    n_checks++; if ({st_wr[5], st_byte[5]} !== {1'b1, 8'h01}) begin n_fail++; $display("FAIL rst_mid_restart_pwr: got wr%b %h expected wr1 01", st_wr[5], st_byte[5]); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_periodic();
    test_nack_mode();
    test_timeout();
    test_en_drop_conv();
    test_en_drop_read();
    test_reset_mid_read();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
